shift_divider_ctrl: RTL and testbench

Controller FSM that sequences an N-bit restoring shift-subtract divider built from the team's left-shift registers. It drives remainder register A, quotient/dividend register Q and divisor register B. It consumes the datapath's compare and zero flags and returns a start/busy/done handshake to the host. One quotient bit is resolved per clock cycle.

---
 rtl/div_pkg.sv | 14 +
 rtl/iter_counter.sv | 27 ++
 rtl/shift_divider_ctrl.sv | 130 +++++++++++++
 tb/tb_shift_divider_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the shift-subtract divider controller.
package div_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    ITER  = 3'd3,
    DONE  = 3'd4
  } div_state_e;

  localparam int DIV_N = 11;

endpackage

// File: rtl/iter_counter.sv
// Iteration counter for the divider: synchronous clear, enable, and a
// terminal-count flag when the count reaches N-1.
module iter_counter #(
  parameter int N  = 11,
  parameter int CW = $clog2(N)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          tc
);

  // Count register: clear wins over enable.
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= {CW{1'b0}};
    end else if (en) begin
      cnt <= cnt + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt <= cnt;
    end
  end

  assign tc = (cnt == CW'(N - 1));

endmodule

// File: rtl/shift_divider_ctrl.sv
// Controller FSM for an N-bit restoring shift-subtract divider; resolves one
// quotient bit per clock and returns a start/busy/done/err handshake.
module shift_divider_ctrl
  import div_pkg::*;
#(
  parameter int N  = DIV_N,
  parameter int CW = $clog2(N)
) (
  input  logic clk,
  input  logic clr,
  input  logic start,
  input  logic ge,
  input  logic b_zero,
  output logic sclr_a,
  output logic ld_q,
  output logic ld_b,
  output logic ld_a,
  output logic sh_a,
  output logic sh_q,
  output logic q_ser,
  output logic busy,
  output logic done,
  output logic err
);

  div_state_e    state_r;
  div_state_e    state_next_s;
  logic          err_r;
  logic          err_next_s;
  logic          cnt_clr_s;
  logic          cnt_en_s;
  logic [CW-1:0] cnt_s;
  logic          cnt_tc_s;

  iter_counter #(.N(N), .CW(CW)) u_cnt (
    .clk (clk),
    .clr (cnt_clr_s),
    .en  (cnt_en_s),
    .cnt (cnt_s),
    .tc  (cnt_tc_s)
  );

  // State and error-flag registers.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_r <= IDLE;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_next_s;
      err_r   <= err_next_s;
    end
  end

  // Next-state and strobe decode; clr forces every strobe low in its own cycle.
  always_comb begin
    state_next_s = state_r;
    err_next_s   = err_r;
    cnt_clr_s    = 1'b0;
    cnt_en_s     = 1'b0;
    sclr_a       = 1'b0;
    ld_q         = 1'b0;
    ld_b         = 1'b0;
    ld_a         = 1'b0;
    sh_a         = 1'b0;
    sh_q         = 1'b0;
    q_ser        = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    if (clr) begin
      state_next_s = IDLE;
      err_next_s   = 1'b0;
      cnt_clr_s    = 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            state_next_s = LOAD;
            err_next_s   = 1'b0;
          end else begin
            state_next_s = IDLE;
          end
        end
        LOAD: begin
          busy         = 1'b1;
          sclr_a       = 1'b1;
          ld_q         = 1'b1;
          ld_b         = 1'b1;
          state_next_s = CHECK;
        end
        CHECK: begin
          busy      = 1'b1;
          cnt_clr_s = 1'b1;
          if (b_zero) begin
            err_next_s   = 1'b1;
            state_next_s = DONE;
          end else begin
            state_next_s = ITER;
          end
        end
        ITER: begin
          busy     = 1'b1;
          sh_q     = 1'b1;
          cnt_en_s = 1'b1;
          // Restore by keeping the shifted A, or commit the difference.
          if (ge) begin
            ld_a  = 1'b1;
            q_ser = 1'b1;
          end else begin
            sh_a  = 1'b1;
          end
          if (cnt_tc_s) begin
            state_next_s = DONE;
          end else begin
            state_next_s = ITER;
          end
        end
        DONE: begin
          done         = 1'b1;
          state_next_s = IDLE;
        end
        default: begin
          state_next_s = IDLE;
        end
      endcase
    end
  end

  assign err = err_r;

endmodule

// File: tb/tb_shift_divider_ctrl.sv
// Directed bench: controller paired with a behavioural 11-bit shift-register
// divider datapath; expected quotients, remainders and latencies are hand-computed.
module tb_shift_divider_ctrl;
  import div_pkg::*;

  localparam int N = 11;

  logic clk = 1'b0;
  logic clr, start, ge, b_zero;
  logic sclr_a, ld_q, ld_b, ld_a, sh_a, sh_q, q_ser, busy, done, err;

  logic [N-1:0] a_r, q_r, b_r, dvd, dvs;
  logic [N:0]   diff_s;
  logic [N-1:0] q_seq;
  int busy_cnt, done_cnt, shq_cnt, lda_cnt, sha_cnt;
  logic stats_clr, mon_en, done_q;
  int checks, errors, n;

  always #5 clk = ~clk;

  shift_divider_ctrl #(.N(N)) u_dut (
    .clk(clk), .clr(clr), .start(start), .ge(ge), .b_zero(b_zero),
    .sclr_a(sclr_a), .ld_q(ld_q), .ld_b(ld_b), .ld_a(ld_a), .sh_a(sh_a),
    .sh_q(sh_q), .q_ser(q_ser), .busy(busy), .done(done), .err(err)
  );

  assign diff_s = {a_r, q_r[N-1]} - {1'b0, b_r};
  assign ge     = ({a_r, q_r[N-1]} >= {1'b0, b_r});
  assign b_zero = (b_r == '0);

  // Behavioural datapath registers plus strobe statistics.
  always @(posedge clk) begin
    if (sclr_a) a_r <= '0;
    else if (ld_a) a_r <= diff_s[N-1:0];
    else if (sh_a) a_r <= {a_r[N-2:0], q_r[N-1]};
    if (ld_q) q_r <= dvd;
    else if (sh_q) q_r <= {q_r[N-2:0], q_ser};
    if (ld_b) b_r <= dvs;
    if (stats_clr) begin
      busy_cnt <= 0; done_cnt <= 0; shq_cnt <= 0; lda_cnt <= 0; sha_cnt <= 0;
      q_seq <= '0;
    end else begin
      busy_cnt <= busy_cnt + int'(busy);
      done_cnt <= done_cnt + int'(done);
      shq_cnt  <= shq_cnt + int'(sh_q);
      lda_cnt  <= lda_cnt + int'(ld_a);
      sha_cnt  <= sha_cnt + int'(sh_a);
      if (sh_q) q_seq <= {q_seq[N-2:0], q_ser};
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Continuous protocol invariants.
  always @(negedge clk) begin
    if (mon_en) begin
      check("ld_a_sh_a_excl", 32'(ld_a & sh_a), 32'd0);
      check("busy_done_excl", 32'(busy & done), 32'd0);
      check("done_one_cycle", 32'(done & done_q), 32'd0);
    end
    done_q <= done;
  end

  task automatic start_div(input logic [N-1:0] x, input logic [N-1:0] y);
    @(negedge clk);
    dvd = x; dvs = y; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int already, output int edges);
    edges = already;
    do begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end while (!done && edges < 40);
  endtask

  task automatic clear_stats();
    @(negedge clk);
    stats_clr = 1'b1;
    @(posedge clk);
    #1 stats_clr = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0; mon_en = 1'b0; stats_clr = 1'b0; done_q = 1'b0;
    clr = 1'b1; start = 1'b0; dvd = '0; dvs = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 32'({sclr_a, ld_q, ld_b, ld_a, sh_a, sh_q, q_ser, busy, done, err}), 32'd0);
    check("reset_state", 32'(u_dut.state_r), 32'(IDLE));
    check("reset_cnt", 32'(u_dut.u_cnt.cnt), 32'd0);
    @(posedge clk);
    #1 clr = 1'b0;
    mon_en = 1'b1;

    // 100 / 7 = 14 r 2
    clear_stats();
    start_div(11'd100, 11'd7);
    wait_done(0, n);
    check("lat_100_7", 32'(n), 32'd13);
    check("err_100_7", 32'(err), 32'd0);
    check("q_100_7", 32'(q_r), 32'd14);
    check("a_100_7", 32'(a_r), 32'd2);
    check("qser_100_7", 32'(q_seq), 32'h00E);
    check("busy_100_7", 32'(busy_cnt), 32'd13);

    // 2047 / 1: every iteration subtracts
    clear_stats();
    start_div(11'd2047, 11'd1);
    wait_done(0, n);
    check("lat_2047_1", 32'(n), 32'd13);
    check("lda_2047_1", 32'(lda_cnt), 32'd11);
    check("sha_2047_1", 32'(sha_cnt), 32'd0);
    check("q_2047_1", 32'(q_r), 32'd2047);
    check("a_2047_1", 32'(a_r), 32'd0);

    // 55 / 0: divide-by-zero
    clear_stats();
    start_div(11'd55, 11'd0);
    wait_done(0, n);
    check("lat_div0", 32'(n), 32'd2);
    check("err_div0", 32'(err), 32'd1);
    repeat (3) @(negedge clk);
    check("err_hold_idle", 32'(err), 32'd1);
    check("busy_div0", 32'(busy_cnt), 32'd2);
    check("shq_div0", 32'(shq_cnt), 32'd0);
    check("lda_div0", 32'(lda_cnt), 32'd0);
    start_div(11'd100, 11'd7);
    @(negedge clk);
    check("err_cleared", 32'(err), 32'd0);
    wait_done(0, n);
    check("lat_after_div0", 32'(n), 32'd13);
    check("q_after_div0", 32'(q_r), 32'd14);

    // start re-pulsed mid-iteration and held through DONE
    clear_stats();
    start_div(11'd100, 11'd7);
    repeat (6) @(posedge clk);
    #1 start = 1'b1;
    wait_done(6, n);
    check("lat_restart", 32'(n), 32'd13);
    @(posedge clk);
    @(negedge clk);
    check("idle_after_done", 32'(busy | done), 32'd0);
    check("single_done", 32'(done_cnt), 32'd1);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("accept_in_idle", 32'(busy), 32'd1);
    wait_done(0, n);
    check("lat_second", 32'(n), 32'd13);
    check("q_second", 32'(q_r), 32'd14);

    // clr during iteration
    start_div(11'd100, 11'd7);
    repeat (7) @(posedge clk);
    #1 clr = 1'b1;
    @(negedge clk);
    check("strobes_in_clr", 32'({sclr_a, ld_q, ld_b, ld_a, sh_a, sh_q, q_ser}), 32'd0);
    @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    check("outputs_after_clr", 32'({sclr_a, ld_q, ld_b, ld_a, sh_a, sh_q, q_ser, busy, done, err}), 32'd0);
    check("state_after_clr", 32'(u_dut.state_r), 32'(IDLE));
    check("cnt_after_clr", 32'(u_dut.u_cnt.cnt), 32'd0);
    start_div(11'd100, 11'd7);
    wait_done(0, n);
    check("lat_after_clr", 32'(n), 32'd13);
    check("q_after_clr", 32'(q_r), 32'd14);
    check("a_after_clr", 32'(a_r), 32'd2);
    check("err_after_clr", 32'(err), 32'd0);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
